// File: rtl/ripple_count_sequencer.sv
// Sequencer for an external ripple up-counter: clears it, issues count pulses,
// waits out ripple settling after each one and checks the sampled value against a shadow count.
module ripple_count_sequencer #(
    parameter int W          = 4,
    parameter int CLR_CYC    = 2,
    parameter int TICK_W     = 1,
    parameter int SETTLE_CYC = 4,
    parameter int VAL_INV    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] target,
    input  logic [W-1:0] cnt_val,
    output logic         cnt_rst_n,
    output logic         cnt_tick,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] count_out
);

    localparam int MAX_A = (CLR_CYC > TICK_W) ? CLR_CYC : TICK_W;
    localparam int MAX_C = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] CLR_LAST    = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_W - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TICK_HI,
        S_TICK_LO,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [W-1:0]   tgt_q, tgt_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic           err_d;
    logic [W-1:0]   count_d;
    logic [W-1:0]   dec;

    function automatic logic [W-1:0] decode_val(input logic [W-1:0] v);
        return (VAL_INV != 0) ? ~v : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q + 1'b1;
        tgt_d    = tgt_q;
        shadow_d = shadow_q;
        err_d    = err;
        count_d  = count_out;
        dec      = decode_val(cnt_val);

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (start) begin
                    tgt_d    = target;
                    shadow_d = '0;
                    err_d    = 1'b0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cyc_q == CLR_LAST) begin
                    state_d = S_SETTLE;
                    cyc_d   = '0;
                end
            end
            S_TICK_HI: begin
                if (cyc_q == TICK_LAST) begin
                    state_d  = S_TICK_LO;
                    cyc_d    = '0;
                    shadow_d = shadow_q + 1'b1;
                end
            end
            S_TICK_LO: begin
                if (cyc_q == TICK_LAST) begin
                    state_d = S_SETTLE;
                    cyc_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    cyc_d   = '0;
                end
            end
            S_CHECK: begin
                // cnt_val is only trusted here, after the settle window has elapsed
                cyc_d   = '0;
                count_d = dec;
                if (dec != shadow_q) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (shadow_q == tgt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_TICK_HI;
                end
            end
            S_DONE: begin
                cyc_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cyc_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition, including a start in IDLE
        if (abort) begin
            state_d  = S_IDLE;
            cyc_d    = '0;
            tgt_d    = tgt_q;
            shadow_d = shadow_q;
            err_d    = err;
            count_d  = count_out;
        end
    end

    // Control state and flop-driven counter interface, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            err       <= 1'b0;
            count_out <= '0;
            cnt_rst_n <= 1'b0;
            cnt_tick  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            err       <= err_d;
            count_out <= count_d;
            cnt_rst_n <= (state_d != S_CLEAR);
            cnt_tick  <= (state_d == S_TICK_HI);
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

    // Target and shadow are always reloaded on an accepted start
    always_ff @(posedge clk) begin
        tgt_q    <= tgt_d;
        shadow_q <= shadow_d;
    end

endmodule

// File: tb/tb_ripple_count_sequencer.sv
// Directed bench for ripple_count_sequencer with a behavioural ripple counter
// that stores the inverted count and can be made to stick at a chosen value.
module tb_ripple_count_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] target;
    logic [3:0] cnt_val;
    logic       cnt_rst_n;
    logic       cnt_tick;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] count_out;

    int checks = 0;
    int errors = 0;

    logic [3:0] model;
    int         pulses;
    logic [3:0] stuck_lim;

    ripple_count_sequencer #(
        .W(4), .CLR_CYC(2), .TICK_W(1), .SETTLE_CYC(4), .VAL_INV(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .target(target),
        .cnt_val(cnt_val),
        .cnt_rst_n(cnt_rst_n),
        .cnt_tick(cnt_tick),
        .busy(busy),
        .done(done),
        .err(err),
        .count_out(count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge cnt_tick or negedge cnt_rst_n) begin
        if (!cnt_rst_n) begin
            model  <= 4'd0;
            pulses <= 0;
        end else begin
            pulses <= pulses + 1;
            if (model < stuck_lim) model <= model + 4'd1;
        end
    end

    assign cnt_val = ~model;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start is sampled at edge 0; returns positioned #1 into cycle 1
    task automatic start_seq(input logic [3:0] t);
        @(negedge clk);
        target = t;
        start  = 1'b1;
        step();
        start  = 1'b0;
        target = ~t;
    endtask

    task automatic wait_done(input int first_cyc, output int dc, output int rlo_first,
                             output int rlo_n, output int busy_n);
        int cyc;
        cyc       = first_cyc;
        dc        = -1;
        rlo_first = -1;
        rlo_n     = 0;
        busy_n    = 0;
        while (cyc <= 400) begin
            if (!cnt_rst_n) begin
                if (rlo_first < 0) rlo_first = cyc;
                rlo_n++;
            end
            if (busy) busy_n++;
            if (done) begin
                dc = cyc;
                break;
            end
            step();
            cyc++;
        end
    endtask

    int dc, rlo_first, rlo_n, busy_n, done_seen;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        target    = 4'd0;
        stuck_lim = 4'd15;
        repeat (2) step();
        check("rst_cnt_rst_n", cnt_rst_n, 0);
        check("rst_cnt_tick", cnt_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count_out", count_out, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step();
        check("idle_cnt_rst_n", cnt_rst_n, 1);

        // target=3
        start_seq(4'd3);
        wait_done(1, dc, rlo_first, rlo_n, busy_n);
        check("t3_done_cycle", dc, 29);
        check("t3_pulses", pulses, 3);
        check("t3_count_out", count_out, 3);
        check("t3_err", err, 0);
        check("t3_clr_cycles", rlo_n, 2);
        step();
        check("t3_done_pulse_len", done, 0);
        check("t3_busy_after", busy, 0);

        // target=0: only the clear is checked
        start_seq(4'd0);
        wait_done(1, dc, rlo_first, rlo_n, busy_n);
        check("t0_done_cycle", dc, 8);
        check("t0_pulses", pulses, 0);
        check("t0_clr_first", rlo_first, 1);
        check("t0_clr_cycles", rlo_n, 2);
        check("t0_count_out", count_out, 0);
        step();

        // target=15, the maximum
        start_seq(4'd15);
        wait_done(1, dc, rlo_first, rlo_n, busy_n);
        check("t15_done_cycle", dc, 113);
        check("t15_pulses", pulses, 15);
        check("t15_count_out", count_out, 15);
        check("t15_err", err, 0);
        check("t15_busy_cycles", busy_n, 113);
        step();
        check("t15_busy_after", busy, 0);

        // counter sticks at 2, target=5
        stuck_lim = 4'd2;
        start_seq(4'd5);
        wait_done(1, dc, rlo_first, rlo_n, busy_n);
        check("stuck_done_cycle", dc, 29);
        check("stuck_pulses", pulses, 3);
        check("stuck_err", err, 1);
        check("stuck_count_out", count_out, 2);
        step();
        check("stuck_err_sticky", err, 1);
        repeat (3) step();
        check("stuck_no_4th_pulse", pulses, 3);
        stuck_lim = 4'd15;

        // abort during the 2nd TICK_HI (cycle 15)
        start_seq(4'd3);
        check("abort_err_cleared", err, 0);
        repeat (14) step();
        check("abort_in_tick_hi", cnt_tick, 1);
        check("abort_pulses_before", pulses, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cnt_tick", cnt_tick, 0);
        check("abort_cnt_rst_n", cnt_rst_n, 1);
        check("abort_count_out_held", count_out, 1);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_seen++;
            step();
        end
        check("abort_no_done", done_seen, 0);
        check("abort_pulses_after", pulses, 2);

        start_seq(4'd1);
        wait_done(1, dc, rlo_first, rlo_n, busy_n);
        check("post_abort_done_cycle", dc, 15);
        check("post_abort_err", err, 0);
        check("post_abort_count_out", count_out, 1);
        step();

        // start and abort together in IDLE: start dropped
        @(negedge clk);
        start  = 1'b1;
        abort  = 1'b1;
        target = 4'd5;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_cnt_rst_n", cnt_rst_n, 1);
        step();
        check("start_abort_busy2", busy, 0);

        // start while busy is ignored
        start_seq(4'd2);
        @(negedge clk);
        start  = 1'b1;
        target = 4'd9;
        step();
        start = 1'b0;
        wait_done(2, dc, rlo_first, rlo_n, busy_n);
        check("busy_start_done_cycle", dc, 22);
        check("busy_start_pulses", pulses, 2);
        check("busy_start_count_out", count_out, 2);
        step();

        // rst mid-SETTLE
        start_seq(4'd1);
        repeat (3) step();
        check("settle_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_cnt_rst_n", cnt_rst_n, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count_out", count_out, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        start_seq(4'd1);
        wait_done(1, dc, rlo_first, rlo_n, busy_n);
        check("after_rst_done_cycle", dc, 15);
        check("after_rst_count_out", count_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
